// File: rtl/fp32_adder_pkg.sv
// fp32_adder_pkg: shared widths and FSM encoding for the bit-serial FP32 adder feeders
package fp32_adder_pkg;
  localparam int FP32_W = 32;
  localparam int OPND_BITS = 2 * FP32_W;
  typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_SHIFT, ST_WAIT} state_t;
endpackage

// File: rtl/fp32_operand_serializer_piso_shreg.sv
// piso_shreg: parallel-load, shift-left register presenting its MSB as the serial output
module piso_shreg
  import fp32_adder_pkg::*;
#(
  parameter int W = OPND_BITS
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic         i_shift,
  input  logic [W-1:0] i_data,
  output logic         o_msb
);
  logic [W-1:0] r_sreg;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_sreg <= '0;
    else if (i_load) r_sreg <= i_data;
    else if (i_shift) r_sreg <= {r_sreg[W-2:0], 1'b0};
  assign o_msb = r_sreg[W-1];
endmodule

// File: rtl/fp32_operand_serializer.sv
// fp32_operand_serializer: accepts an FP32 operand pair and streams A then B MSB-first to add_float
module fp32_operand_serializer
  import fp32_adder_pkg::*;
#(
  parameter int GO_IDLE_CYCLES = 2,
  parameter int DONE_TIMEOUT   = 64
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_op_valid,
  output logic              o_op_ready,
  input  logic [FP32_W-1:0] i_op_a,
  input  logic [FP32_W-1:0] i_op_b,
  output logic              o_go,
  output logic              o_inpab,
  input  logic              i_done,
  output logic              o_busy,
  output logic              o_xfer_done,
  output logic              o_timeout
);
  localparam int IW = $clog2(GO_IDLE_CYCLES + 1);
  localparam int WW = $clog2(DONE_TIMEOUT);
  state_t          r_state;
  logic [5:0]      r_bit_cnt;
  logic [WW-1:0]   r_wait_cnt;
  logic [IW-1:0]   r_idle_cnt;
  logic            w_accept, w_shift, w_idle_sat, w_msb, w_expire;
  assign w_accept   = r_state == ST_IDLE && i_op_valid && o_op_ready;
  assign w_shift    = r_state == ST_ARM || r_state == ST_SHIFT;
  assign w_idle_sat = r_idle_cnt >= IW'(GO_IDLE_CYCLES - 1);
  assign w_expire   = r_wait_cnt == WW'(DONE_TIMEOUT - 1);
  piso_shreg #(.W(OPND_BITS)) u_sreg (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (w_accept),
    .i_shift (w_shift),
    .i_data  ({i_op_a, i_op_b}),
    .o_msb   (w_msb)
  );
  // ARM drives A[31] while the adder first sees go=0; SHIFT supplies the remaining 63 bits
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= '0;
      r_wait_cnt  <= '0;
      r_idle_cnt  <= '0;
      o_op_ready  <= 1'b0;
      o_go        <= 1'b1;
      o_inpab     <= 1'b0;
      o_busy      <= 1'b0;
      o_xfer_done <= 1'b0;
      o_timeout   <= 1'b0;
    end else begin
      o_xfer_done <= 1'b0;
      o_timeout   <= 1'b0;
      case (r_state)
        ST_IDLE:
          if (w_accept) begin
            r_state    <= ST_ARM;
            o_go       <= 1'b0;
            o_busy     <= 1'b1;
            o_op_ready <= 1'b0;
            r_idle_cnt <= '0;
          end else begin
            r_idle_cnt <= w_idle_sat ? IW'(GO_IDLE_CYCLES) : r_idle_cnt + 1'b1;
            o_op_ready <= w_idle_sat;
          end
        ST_ARM: begin
          o_inpab   <= w_msb;
          r_bit_cnt <= '0;
          r_state   <= ST_SHIFT;
        end
        ST_SHIFT: begin
          o_inpab   <= w_msb;
          r_bit_cnt <= r_bit_cnt + 1'b1;
          if (r_bit_cnt == 6'(OPND_BITS - 2)) begin
            r_state    <= ST_WAIT;
            r_wait_cnt <= '0;
          end
        end
        ST_WAIT: begin
          o_inpab <= 1'b0;
          if (i_done || w_expire) begin
            r_state     <= ST_IDLE;
            o_go        <= 1'b1;
            o_busy      <= 1'b0;
            o_xfer_done <= i_done;
            o_timeout   <= !i_done;
          end else r_wait_cnt <= r_wait_cnt + 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp32_operand_serializer.sv
// tb_fp32_operand_serializer: directed checks of handshake, serial stream, done/timeout exits and reset abort
module tb_fp32_operand_serializer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        go, inpab, done = 1'b0, busy, xfer_done, timeout;
  int          n_asserts = 0;
  int          n_fail = 0;
  fp32_operand_serializer dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_op_valid  (op_valid),
    .o_op_ready  (op_ready),
    .i_op_a      (op_a),
    .i_op_b      (op_b),
    .o_go        (go),
    .o_inpab     (inpab),
    .i_done      (done),
    .o_busy      (busy),
    .o_xfer_done (xfer_done),
    .o_timeout   (timeout)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic run_pair(input logic [31:0] a, input logic [31:0] b, input bit hold,
                          input int done_at, output int waits);
    logic [63:0] got;
    bit          pulse;
    op_a = a;
    op_b = b;
    op_valid = 1'b1;
    waits = 0;
    while (!op_ready && waits < 20) begin
      tick();
      waits++;
    end
    chk("ready_before_accept", {63'd0, op_ready}, 64'd1);
    tick();
    if (!hold) op_valid = 1'b0;
    op_a = $urandom;
    op_b = $urandom;
    chk("go_low_after_accept", {63'd0, go}, 64'd0);
    chk("busy_after_accept", {63'd0, busy}, 64'd1);
    chk("ready_low_after_accept", {63'd0, op_ready}, 64'd0);
    pulse = 1'b0;
    for (int i = 0; i < 64; i++) begin
      done = (i == done_at);
      tick();
      got[63-i] = inpab;
      pulse |= xfer_done | timeout;
    end
    done = 1'b0;
    chk("stream", got, {a, b});
    chk("no_pulse_in_stream", {63'd0, pulse}, 64'd0);
  endtask
  task automatic finish_done;
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("xfer_done_pulse", {63'd0, xfer_done}, 64'd1);
    chk("no_timeout_on_done", {63'd0, timeout}, 64'd0);
    chk("go_high_after_done", {63'd0, go}, 64'd1);
    chk("busy_low_after_done", {63'd0, busy}, 64'd0);
    tick();
    chk("xfer_done_single", {63'd0, xfer_done}, 64'd0);
  endtask
  initial begin
    int waits, first;
    bit early;
    #99;
    chk("rst_go", {63'd0, go}, 64'd1);
    chk("rst_inpab", {63'd0, inpab}, 64'd0);
    chk("rst_ready", {63'd0, op_ready}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    #1 rst_n = 1'b1;
    tick();
    chk("ready_after_1", {63'd0, op_ready}, 64'd0);
    tick();
    chk("ready_after_2", {63'd0, op_ready}, 64'd1);
    run_pair(32'h03780000, 32'h82780000, 1'b0, -1, waits);
    finish_done();
    run_pair(32'h3F800000, 32'hBF800000, 1'b0, -1, waits);
    first = 0;
    for (int k = 1; k <= 80 && first == 0; k++) begin
      tick();
      if (timeout) first = k;
    end
    chk("timeout_cycle", 64'(first), 64'd64);
    chk("go_high_after_timeout", {63'd0, go}, 64'd1);
    chk("busy_low_after_timeout", {63'd0, busy}, 64'd0);
    chk("no_xfer_on_timeout", {63'd0, xfer_done}, 64'd0);
    tick();
    chk("timeout_single", {63'd0, timeout}, 64'd0);
    run_pair(32'h3F800000, 32'h40000000, 1'b1, -1, waits);
    finish_done();
    run_pair(32'h40400000, 32'hC0800000, 1'b1, -1, waits);
    chk("idle_gap", 64'(waits + 2 >= 2 && waits + 2 <= 3), 64'd1);
    op_valid = 1'b0;
    finish_done();
    op_a = 32'hDEADBEEF;
    op_b = 32'h12345678;
    op_valid = 1'b1;
    waits = 0;
    while (!op_ready && waits < 20) begin
      tick();
      waits++;
    end
    tick();
    op_valid = 1'b0;
    for (int i = 0; i < 21; i++) tick();
    rst_n = 1'b0;
    #1;
    chk("abort_go", {63'd0, go}, 64'd1);
    chk("abort_inpab", {63'd0, inpab}, 64'd0);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_ready", {63'd0, op_ready}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_pair(32'hA5A5F00F, 32'h0F0F3C3C, 1'b0, -1, waits);
    finish_done();
    run_pair(32'h41200000, 32'hC1A00000, 1'b0, 10, waits);
    early = 1'b0;
    for (int k = 1; k <= 63; k++) begin
      tick();
      early |= timeout | xfer_done;
    end
    chk("no_exit_before_expiry", {63'd0, early}, 64'd0);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("tie_xfer_done", {63'd0, xfer_done}, 64'd1);
    chk("tie_timeout", {63'd0, timeout}, 64'd0);
    chk("tie_go", {63'd0, go}, 64'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
